// File: rtl/stack_alu_pkg.sv
// Shared opcode, token-kind and sequencer state encodings for the stack ALU slice.
package stack_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b100,
    OP_MUL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    TOK_PUSH = 2'b00,
    TOK_ADD  = 2'b01,
    TOK_MUL  = 2'b10,
    TOK_END  = 2'b11
  } tok_kind_e;

  typedef enum logic [3:0] {
    FETCH,
    OP,
    CAP,
    POP_A,
    POP_B,
    PUSH_R,
    FIN_POP,
    FIN_CAP,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/stack_alu_sequencer.sv
// Evaluates postfix token streams on an external stack ALU and returns one result
// per expression; errors discard the rest of the expression and drain the ALU stack.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_value,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_input_data,
  input  logic [N-1:0] alu_output_data,
  input  logic         alu_overflow,
  input  logic         alu_success,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error
);

  localparam int DW = $clog2(MAX_SIZE + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_SIZE);

  seq_state_e    state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  val_q, val_d;
  alu_op_e       opcode_q, opcode_d;
  logic [N-1:0]  in_data_q, in_data_d;
  logic          tok_ready_q, tok_ready_d;
  logic          res_valid_q, res_valid_d;
  logic [N-1:0]  res_data_q, res_data_d;
  logic          res_ovf_q, res_ovf_d;
  logic          res_err_q, res_err_d;
  logic          drain, finish;

  // Outputs are registered: every op is decided on the transition into the
  // state that drives it, so the ALU result lands in the following state.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    val_d       = val_q;
    opcode_d    = OP_NOP;
    in_data_d   = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;
    drain       = 1'b0;
    finish      = 1'b0;

    case (state_q)
      FETCH: begin
        if (tok_valid && tok_ready_q) begin
          case (tok_kind_e'(tok_kind))
            TOK_PUSH: begin
              if (!err_q) begin
                if (depth_q == DEPTH_MAX) begin
                  err_d = 1'b1;
                end else begin
                  opcode_d  = OP_PUSH;
                  in_data_d = tok_value;
                end
              end
            end
            TOK_ADD, TOK_MUL: begin
              if (!err_q) begin
                if (depth_q < DW'(2)) begin
                  err_d = 1'b1;
                end else begin
                  state_d  = OP;
                  opcode_d = (tok_kind_e'(tok_kind) == TOK_MUL) ? OP_MUL : OP_ADD;
                end
              end
            end
            default: begin
              if (err_q || depth_q != DW'(1)) begin
                err_d = 1'b1;
                drain = 1'b1;
              end else begin
                state_d  = FIN_POP;
                opcode_d = OP_POP;
              end
            end
          endcase
        end
      end
      OP:      state_d = CAP;
      CAP: begin
        val_d = alu_output_data;
        ovf_d = ovf_q | alu_overflow;
        if (!alu_success) begin
          err_d   = 1'b1;
          state_d = FETCH;
        end else begin
          state_d  = POP_A;
          opcode_d = OP_POP;
        end
      end
      POP_A: begin
        state_d  = POP_B;
        opcode_d = OP_POP;
      end
      POP_B: begin
        state_d   = PUSH_R;
        opcode_d  = OP_PUSH;
        in_data_d = val_q;
      end
      PUSH_R:  state_d = FETCH;
      FIN_POP: state_d = FIN_CAP;
      FIN_CAP: begin
        val_d = alu_output_data;
        if (!alu_success) err_d = 1'b1;
        finish = 1'b1;
      end
      DRAIN:   drain = 1'b1;
      DONE: begin
        if (res_ready) begin
          state_d     = FETCH;
          res_valid_d = 1'b0;
          err_d       = 1'b0;
          ovf_d       = 1'b0;
          depth_d     = '0;
        end
      end
      default: state_d = FETCH;
    endcase

    if (drain) begin
      if (depth_q == '0) begin
        finish = 1'b1;
      end else begin
        state_d  = DRAIN;
        opcode_d = OP_POP;
      end
    end

    if (finish) begin
      state_d     = DONE;
      res_valid_d = 1'b1;
      res_err_d   = err_d;
      res_ovf_d   = ovf_d;
      res_data_d  = err_d ? '0 : val_d;
    end

    // Depth mirrors exactly the PUSH/POP ops handed to the ALU.
    if (opcode_d == OP_PUSH)     depth_d = depth_d + 1'b1;
    else if (opcode_d == OP_POP) depth_d = depth_d - 1'b1;

    tok_ready_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      depth_q     <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      val_q       <= '0;
      opcode_q    <= OP_NOP;
      in_data_q   <= '0;
      tok_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      val_q       <= val_d;
      opcode_q    <= opcode_d;
      in_data_q   <= in_data_d;
      tok_ready_q <= tok_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
    end
  end

  assign tok_ready      = tok_ready_q;
  assign alu_opcode     = opcode_q;
  assign alu_input_data = in_data_q;
  assign res_valid      = res_valid_q;
  assign res_data       = res_data_q;
  assign res_overflow   = res_ovf_q;
  assign res_error      = res_err_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench: sequencer paired with a behavioural stack ALU model.
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int N        = 4;
  localparam int MAX_SIZE = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_kind;
  logic [N-1:0] tok_value;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_input_data;
  logic [N-1:0] alu_output_data;
  logic         alu_overflow;
  logic         alu_success;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic         res_error;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .MAX_SIZE(MAX_SIZE)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_value(tok_value),
    .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
    .alu_output_data(alu_output_data), .alu_overflow(alu_overflow), .alu_success(alu_success),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_overflow(res_overflow), .res_error(res_error)
  );

  // Stack ALU model: operators peek the top two entries, results valid next cycle.
  logic signed [N-1:0] stk [MAX_SIZE];
  int sp;
  always @(posedge clk) begin : alu_model
    int x;
    if (rst) begin
      sp = 0;
      alu_output_data <= '0;
      alu_overflow    <= 1'b0;
      alu_success     <= 1'b0;
    end else begin
      case (alu_opcode)
        3'b110: begin
          alu_overflow <= 1'b0;
          if (sp < MAX_SIZE) begin
            stk[sp] = alu_input_data;
            sp++;
            alu_success <= 1'b1;
          end else alu_success <= 1'b0;
        end
        3'b111: begin
          alu_overflow <= 1'b0;
          if (sp > 0) begin
            sp--;
            alu_output_data <= stk[sp];
            alu_success     <= 1'b1;
          end else alu_success <= 1'b0;
        end
        3'b100, 3'b101: begin
          if (sp >= 2) begin
            if (alu_opcode == 3'b100) x = int'(stk[sp-1]) + int'(stk[sp-2]);
            else                      x = int'(stk[sp-1]) * int'(stk[sp-2]);
            alu_output_data <= x[N-1:0];
            alu_overflow    <= (x > 7) || (x < -8);
            alu_success     <= 1'b1;
          end else begin
            alu_overflow <= 1'b0;
            alu_success  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  logic       rec = 1'b0;
  logic [2:0] trace [$];
  always @(posedge clk) if (rec) trace.push_back(alu_opcode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_op(input logic [2:0] op);
    int c = 0;
    foreach (trace[i]) if (trace[i] == op) c++;
    return c;
  endfunction

  task automatic send_tok(input logic [1:0] k, input logic [N-1:0] v);
    int w = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_value = v;
    while (!tok_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!tok_ready) check("tok_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input string tag);
    int w = 0;
    @(negedge clk);
    tok_valid = 1'b0;
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 32'(res_valid), 32'd0);
    check({tag, "_alu_depth"}, 32'(sp), 32'd0);
  endtask

  initial begin
    logic [2:0] nz [$];
    logic [2:0] exp_tr [7] = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110, 3'b111};
    int add_idx;

    rst = 1'b1; tok_valid = 1'b0; tok_kind = '0; tok_value = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_opcode", 32'(alu_opcode), 32'd0);
    check("rst_indata", 32'(alu_input_data), 32'd0);
    check("rst_tok_ready", 32'(tok_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_error), 32'd0);
    check("rst_res_ovf", 32'(res_overflow), 32'd0);
    rst = 1'b0;

    // 3 2 + -> 5, with opcode trace
    trace.delete();
    rec = 1'b1;
    send_tok(2'b00, 4'd3); send_tok(2'b00, 4'd2); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_result("t1");
    rec = 1'b0;
    check("t1_data", 32'(res_data), 32'd5);
    check("t1_ovf", 32'(res_overflow), 32'd0);
    check("t1_err", 32'(res_error), 32'd0);
    nz.delete();
    add_idx = -1;
    foreach (trace[i]) begin
      if (trace[i] != 3'b000) nz.push_back(trace[i]);
      if (trace[i] == 3'b100 && add_idx < 0) add_idx = i;
    end
    check("t1_trace_len", 32'(nz.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      if (i < nz.size()) check($sformatf("t1_trace_%0d", i), 32'(nz[i]), 32'(exp_tr[i]));
    if (add_idx >= 0 && add_idx + 1 < trace.size())
      check("t1_cap_nop", 32'(trace[add_idx+1]), 32'd0);
    else
      check("t1_add_seen", 32'd0, 32'd1);
    handshake("t1");

    // 7 1 + -> -8 with overflow
    send_tok(2'b00, 4'd7); send_tok(2'b00, 4'd1); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_result("t2");
    check("t2_data", 32'(res_data), 32'h8);
    check("t2_ovf", 32'(res_overflow), 32'd1);
    check("t2_err", 32'(res_error), 32'd0);
    handshake("t2");

    // 3 -2 * 1 + -> -5
    send_tok(2'b00, 4'd3); send_tok(2'b00, 4'hE); send_tok(2'b10, 4'd0);
    send_tok(2'b00, 4'd1); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_result("t3");
    check("t3_data", 32'(res_data), 32'hB);
    check("t3_ovf", 32'(res_overflow), 32'd0);
    check("t3_err", 32'(res_error), 32'd0);
    handshake("t3");

    // 4 + 1 end -> operator underflow, one drain pop
    trace.delete();
    rec = 1'b1;
    send_tok(2'b00, 4'd4); send_tok(2'b01, 4'd0); send_tok(2'b00, 4'd1); send_tok(2'b11, 4'd0);
    wait_result("t4");
    rec = 1'b0;
    check("t4_err", 32'(res_error), 32'd1);
    check("t4_data", 32'(res_data), 32'd0);
    check("t4_pops", 32'(count_op(3'b111)), 32'd1);
    check("t4_pushes", 32'(count_op(3'b110)), 32'd1);
    check("t4_adds", 32'(count_op(3'b100)), 32'd0);
    handshake("t4");

    // 1 2 end -> depth 2 at end, two drain pops, held result
    trace.delete();
    rec = 1'b1;
    send_tok(2'b00, 4'd1); send_tok(2'b00, 4'd2); send_tok(2'b11, 4'd0);
    wait_result("t5");
    rec = 1'b0;
    check("t5_pops", 32'(count_op(3'b111)), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_hold_valid_%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("t5_hold_err_%0d", i), 32'(res_error), 32'd1);
      check($sformatf("t5_hold_data_%0d", i), 32'(res_data), 32'd0);
      @(negedge clk);
    end
    handshake("t5");

    // reset while in CAP, then a fresh expression
    send_tok(2'b00, 4'd3); send_tok(2'b00, 4'd2); send_tok(2'b01, 4'd0);
    @(posedge clk);
    @(negedge clk);
    tok_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_opcode", 32'(alu_opcode), 32'd0);
    check("t6_rst_res_valid", 32'(res_valid), 32'd0);
    check("t6_rst_tok_ready", 32'(tok_ready), 32'd0);
    rst = 1'b0;
    send_tok(2'b00, 4'd6); send_tok(2'b11, 4'd0);
    wait_result("t6");
    check("t6_data", 32'(res_data), 32'd6);
    check("t6_err", 32'(res_error), 32'd0);
    handshake("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
